// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one external memory port between the instruction
// fetch requester (I) and the data requester (D). Data wins arbitration unless
// fetch has been passed over STARVE_LIMIT times in a row. Every output is
// registered. The optional access timeout is enabled by defining
// MEM_ARB_TIMEOUT_EN; without it the access states wait for mem_ready forever
// and err is tied low.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        mem_read_en,
  output logic        mem_write_en,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    I_ACC = 2'd1,
    D_ACC = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  starve_reg, starve_next;
  logic [31:0] mem_addr_next, mem_wdata_next;
  logic [3:0]  mem_be_next;
  logic        mem_read_en_next, mem_write_en_next;
  logic [31:0] i_rdata_next, d_rdata_next;
  logic        i_ready_next, d_ready_next, busy_next;
  logic        d_wins;

  // Data has priority unless fetch is waiting and has been starved too long
  assign d_wins = d_req && (!i_req || (starve_reg < 4'(STARVE_LIMIT)));

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_reg, tmo_next;
  logic             err_next;
  logic             timeout_hit;

  // Counter holds the number of completed cycles in the access state, so the
  // last permitted cycle is TIMEOUT_CYCLES-1; a mem_ready then still wins.
  assign timeout_hit = (tmo_reg == TMO_W'(TIMEOUT_CYCLES - 1)) && !mem_ready;
`endif

  // Next-state, arbitration and registered-output computation
  always_comb begin
    state_next        = state_reg;
    starve_next       = starve_reg;
    mem_addr_next     = mem_addr;
    mem_wdata_next    = mem_wdata;
    mem_be_next       = mem_be;
    mem_read_en_next  = 1'b0;
    mem_write_en_next = 1'b0;
    i_rdata_next      = i_rdata;
    d_rdata_next      = d_rdata;
    i_ready_next      = 1'b0;
    d_ready_next      = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    tmo_next          = tmo_reg;
    err_next          = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (!i_req) begin
          starve_next = '0;
        end
        if (d_wins) begin
          state_next        = D_ACC;
          mem_addr_next     = d_addr;
          mem_wdata_next    = d_wdata;
          mem_be_next       = d_we ? d_be : 4'b1111;
          mem_write_en_next = d_we;
          mem_read_en_next  = !d_we;
          if (i_req && (starve_reg != 4'hF)) begin
            starve_next = starve_reg + 4'd1;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          tmo_next = '0;
`endif
        end else if (i_req) begin
          state_next       = I_ACC;
          mem_addr_next    = i_addr;
          mem_be_next      = 4'b1111;
          mem_read_en_next = 1'b1;
          starve_next      = '0;
`ifdef MEM_ARB_TIMEOUT_EN
          tmo_next = '0;
`endif
        end
      end
      I_ACC, D_ACC: begin
        if (mem_ready) begin
          state_next = RESP;
          if (state_reg == I_ACC) begin
            i_rdata_next = mem_rdata;
            i_ready_next = 1'b1;
          end else begin
            d_rdata_next = mem_write_en ? 32'h0 : mem_rdata;
            d_ready_next = 1'b1;
          end
`ifdef MEM_ARB_TIMEOUT_EN
        end else if (timeout_hit) begin
          state_next = RESP;
          err_next   = 1'b1;
          if (state_reg == I_ACC) begin
            i_rdata_next = 32'hDEADBEEF;
            i_ready_next = 1'b1;
          end else begin
            d_rdata_next = 32'hDEADBEEF;
            d_ready_next = 1'b1;
          end
`endif
        end else begin
          // Still waiting: keep the strobes asserted
          mem_read_en_next  = mem_read_en;
          mem_write_en_next = mem_write_en;
`ifdef MEM_ARB_TIMEOUT_EN
          tmo_next = tmo_reg + 1'b1;
`endif
        end
      end
      RESP: begin
        // Requests are ignored here so a still-held request is not serviced twice
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    busy_next = (state_next != IDLE);
  end

  // State and registered outputs; reset drops strobes immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      starve_reg   <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_be       <= '0;
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
      i_rdata      <= '0;
      d_rdata      <= '0;
      i_ready      <= 1'b0;
      d_ready      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_reg    <= state_next;
      starve_reg   <= starve_next;
      mem_addr     <= mem_addr_next;
      mem_wdata    <= mem_wdata_next;
      mem_be       <= mem_be_next;
      mem_read_en  <= mem_read_en_next;
      mem_write_en <= mem_write_en_next;
      i_rdata      <= i_rdata_next;
      d_rdata      <= d_rdata_next;
      i_ready      <= i_ready_next;
      d_ready      <= d_ready_next;
      busy         <= busy_next;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  // Access-cycle counter and the timeout error pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_reg <= '0;
      err     <= 1'b0;
    end else begin
      tmo_reg <= tmo_next;
      err     <= err_next;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a memory model checks each access
// against an expected-access queue, and a response monitor checks each ready
// pulse against an expected-response queue.
module tb_mem_port_arbiter;

  localparam int STARVE_LIMIT   = 4;
  localparam int TIMEOUT_CYCLES = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_ready;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        busy;
  logic        err;

  mem_port_arbiter #(
    .STARVE_LIMIT  (STARVE_LIMIT),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_ready     (i_ready),
    .i_rdata     (i_rdata),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_be        (d_be),
    .d_ready     (d_ready),
    .d_rdata     (d_rdata),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_be      (mem_be),
    .mem_read_en (mem_read_en),
    .mem_write_en(mem_write_en),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        chk_wdata;
  } acc_t;

  typedef struct {
    logic        is_d;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  acc_t acc_q[$];
  rsp_t rsp_q[$];
  int   acc_start_cyc[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  int wait_cycles  = 0;
  bit never_ready  = 1'b0;
  int acc_cnt      = 0;
  int last_acc_len = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents seen by the model; fetch at 0x40 returns the NOP opcode
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h40) return 32'h0000_0013;
    return {a[15:0] ^ 16'hA5C3, a[15:0]};
  endfunction

  function automatic acc_t mk_acc(input logic [31:0] a, input logic we, input logic [3:0] be,
                                  input logic [31:0] wd, input logic chk);
    acc_t x;
    x.addr = a; x.we = we; x.be = be; x.wdata = wd; x.chk_wdata = chk;
    return x;
  endfunction

  function automatic rsp_t mk_rsp(input logic is_d, input logic [31:0] data, input logic e);
    rsp_t x;
    x.is_d = is_d; x.data = data; x.err = e;
    return x;
  endfunction

  // Memory model and response monitor, both evaluated on the falling edge
  initial begin : model
    acc_t        cur;
    rsp_t        r;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_be;
    logic        s_rd, s_wr;
    forever begin
      @(negedge clk);
      if (mem_read_en || mem_write_en) begin
        if (acc_cnt == 0) begin
          s_addr = mem_addr; s_wdata = mem_wdata; s_be = mem_be;
          s_rd = mem_read_en; s_wr = mem_write_en;
          acc_start_cyc.push_back(cyc);
          n_checks++;
          if (acc_q.size() == 0) begin
            $display("FAIL access_unexpected: got addr=%h rd=%0b wr=%0b, required no access",
                     mem_addr, mem_read_en, mem_write_en);
          end else begin
            cur = acc_q.pop_front();
            if (mem_addr !== cur.addr || mem_write_en !== cur.we || mem_read_en !== !cur.we ||
                mem_be !== cur.be || (cur.chk_wdata && mem_wdata !== cur.wdata)) begin
              $display("FAIL access_fields: got addr=%h wr=%0b rd=%0b be=%b wdata=%h, required addr=%h we=%0b be=%b wdata=%h",
                       mem_addr, mem_write_en, mem_read_en, mem_be, mem_wdata,
                       cur.addr, cur.we, cur.be, cur.wdata);
            end else begin
              n_pass++;
            end
          end
        end else begin
          n_checks++;
          if (mem_addr !== s_addr || mem_wdata !== s_wdata || mem_be !== s_be ||
              mem_read_en !== s_rd || mem_write_en !== s_wr) begin
            $display("FAIL access_stable: cycle %0d got addr=%h be=%b rd=%0b wr=%0b, required addr=%h be=%b rd=%0b wr=%0b",
                     acc_cnt, mem_addr, mem_be, mem_read_en, mem_write_en, s_addr, s_be, s_rd, s_wr);
          end else begin
            n_pass++;
          end
        end
        acc_cnt++;
        if (!never_ready && acc_cnt > wait_cycles) begin
          mem_ready = 1'b1;
          mem_rdata = mem_word(mem_addr);
        end else begin
          mem_ready = 1'b0;
          mem_rdata = $urandom;
        end
      end else begin
        if (acc_cnt != 0) last_acc_len = acc_cnt;
        acc_cnt = 0;
        // Stray mem_ready outside an access must be ignored
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end

      if (i_ready && d_ready) begin
        n_checks++;
        $display("FAIL ready_both: got i_ready=1 d_ready=1, required at most one");
      end
      if (i_ready) begin
        n_checks++;
        if (rsp_q.size() == 0) begin
          $display("FAIL i_ready_unexpected: got i_ready=1 i_rdata=%h, required no pulse", i_rdata);
        end else begin
          r = rsp_q.pop_front();
          if (r.is_d !== 1'b0 || i_rdata !== r.data || err !== r.err) begin
            $display("FAIL i_response: got who=I i_rdata=%h err=%0b, required who=%s data=%h err=%0b",
                     i_rdata, err, r.is_d ? "D" : "I", r.data, r.err);
          end else begin
            n_pass++;
          end
        end
      end
      if (d_ready) begin
        n_checks++;
        if (rsp_q.size() == 0) begin
          $display("FAIL d_ready_unexpected: got d_ready=1 d_rdata=%h, required no pulse", d_rdata);
        end else begin
          r = rsp_q.pop_front();
          if (r.is_d !== 1'b1 || d_rdata !== r.data || err !== r.err) begin
            $display("FAIL d_response: got who=D d_rdata=%h err=%0b, required who=%s data=%h err=%0b",
                     d_rdata, err, r.is_d ? "D" : "I", r.data, r.err);
          end else begin
            n_pass++;
          end
        end
      end
      if (!i_ready && !d_ready && err !== 1'b0) begin
        n_checks++;
        $display("FAIL err_stray: got err=%0b without ready, required 0", err);
      end
    end
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({i_ready, i_rdata, d_ready, d_rdata, mem_addr, mem_wdata, mem_be,
         mem_read_en, mem_write_en, busy, err} !== '0) begin
      $display("FAIL reset_outputs: got mem_addr=%h be=%b rd=%0b wr=%0b busy=%0b, required all 0",
               mem_addr, mem_be, mem_read_en, mem_write_en, busy);
    end else begin
      n_pass++;
    end
    reset = 1'b1;
    $display("reset released at cycle %0d", cyc);
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    wait_cycles = 20;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_wdata = 32'h1111_1111; d_be = 4'b0011;
    acc_q.push_back(mk_acc(32'h100, 1'b0, 4'b1111, 32'h1111_1111, 1'b1));
    @(negedge clk);
    n_checks++;
    if (mem_read_en !== 1'b1 || busy !== 1'b1) begin
      $display("FAIL midrst_strobe_before: got rd=%0b busy=%0b, required 1 1", mem_read_en, busy);
    end else begin
      n_pass++;
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (mem_read_en !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL midrst_strobe_drop: got rd=%0b busy=%0b, required 0 0", mem_read_en, busy);
    end else begin
      n_pass++;
    end
    d_req = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({i_ready, i_rdata, d_ready, d_rdata, mem_addr, mem_wdata, mem_be,
         mem_read_en, mem_write_en, busy, err} !== '0) begin
      $display("FAIL midrst_after: got mem_addr=%h d_rdata=%h rd=%0b busy=%0b, required all 0",
               mem_addr, d_rdata, mem_read_en, busy);
    end else begin
      n_pass++;
    end
    wait_cycles = 0;
    $display("reset mid-access done at cycle %0d", cyc);
  endtask

  task automatic test_single_fetch();
    int t0;
    bit seen = 1'b0;
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h0000_0040;
    acc_q.push_back(mk_acc(32'h40, 1'b0, 4'b1111, 32'h0, 1'b0));
    rsp_q.push_back(mk_rsp(1'b0, 32'h0000_0013, 1'b0));
    t0 = cyc;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (i_ready) seen = 1'b1;
    end
    i_req = 1'b0;
    n_checks++;
    if (!seen || (cyc - t0) != 2) begin
      $display("FAIL fetch_latency: got seen=%0b edges=%0d, required seen=1 edges=2", seen, cyc - t0);
    end else begin
      n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if (i_ready !== 1'b0 || i_rdata !== 32'h13 || busy !== 1'b0) begin
      $display("FAIL fetch_after: got i_ready=%0b i_rdata=%h busy=%0b, required 0 00000013 0",
               i_ready, i_rdata, busy);
    end else begin
      n_pass++;
    end
    $display("single fetch done at cycle %0d", cyc);
  endtask

  task automatic test_simultaneous();
    int d_seen = 0;
    int i_seen = 0;
    acc_start_cyc.delete();
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h44;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hCAFE_BABE; d_be = 4'b0011;
    acc_q.push_back(mk_acc(32'h200, 1'b1, 4'b0011, 32'hCAFE_BABE, 1'b1));
    acc_q.push_back(mk_acc(32'h44, 1'b0, 4'b1111, 32'h0, 1'b0));
    rsp_q.push_back(mk_rsp(1'b1, 32'h0, 1'b0));
    rsp_q.push_back(mk_rsp(1'b0, mem_word(32'h44), 1'b0));
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (d_ready) begin d_seen++; d_req = 1'b0; d_we = 1'b0; end
      if (i_ready) begin i_seen++; i_req = 1'b0; end
    end
    n_checks++;
    if (d_seen != 1 || i_seen != 1 || acc_start_cyc.size() != 2) begin
      $display("FAIL simul_counts: got d=%0d i=%0d accesses=%0d, required 1 1 2",
               d_seen, i_seen, acc_start_cyc.size());
    end else if (acc_start_cyc[1] - acc_start_cyc[0] != 3) begin
      $display("FAIL simul_spacing: got %0d cycles between accesses, required 3",
               acc_start_cyc[1] - acc_start_cyc[0]);
    end else begin
      n_pass++;
    end
    $display("simultaneous requests done at cycle %0d", cyc);
  endtask

  task automatic test_starvation();
    int d_idx = 0;
    int i_idx = 0;
    int dk = 0;
    int ik = 0;
    // Grant order: D0..D3, I0, D4..D7, I1, D8
    for (int g = 0; g < 11; g++) begin
      if (g == 4 || g == 9) begin
        acc_q.push_back(mk_acc(32'h2000 + 32'(ik * 4), 1'b0, 4'b1111, 32'h0, 1'b0));
        rsp_q.push_back(mk_rsp(1'b0, mem_word(32'h2000 + 32'(ik * 4)), 1'b0));
        ik++;
      end else begin
        acc_q.push_back(mk_acc(32'h1000 + 32'(dk * 4), 1'b0, 4'b1111, 32'(dk), 1'b1));
        rsp_q.push_back(mk_rsp(1'b1, mem_word(32'h1000 + 32'(dk * 4)), 1'b0));
        dk++;
      end
    end
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1000; d_wdata = 32'h0; d_be = 4'b0101;
    i_req = 1'b1; i_addr = 32'h2000;
    for (int k = 0; k < 200 && (d_idx < 9 || i_idx < 2); k++) begin
      @(negedge clk);
      if (d_ready) begin
        d_idx++;
        if (d_idx < 9) begin
          d_addr = 32'h1000 + 32'(d_idx * 4);
          d_wdata = 32'(d_idx);
        end else begin
          d_req = 1'b0;
        end
      end
      if (i_ready) begin
        i_idx++;
        if (i_idx < 2) i_addr = 32'h2000 + 32'(i_idx * 4);
        else i_req = 1'b0;
      end
    end
    d_req = 1'b0; i_req = 1'b0;
    n_checks++;
    if (d_idx != 9 || i_idx != 2) begin
      $display("FAIL starve_complete: got d=%0d i=%0d, required 9 2", d_idx, i_idx);
    end else begin
      n_pass++;
    end
    repeat (2) @(negedge clk);
    $display("starvation sequence done at cycle %0d", cyc);
  endtask

  task automatic test_wait_states();
    bit seen = 1'b0;
    last_acc_len = 0;
    wait_cycles = 5;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_wdata = 32'h0; d_be = 4'b0001;
    acc_q.push_back(mk_acc(32'h300, 1'b0, 4'b1111, 32'h0, 1'b1));
    rsp_q.push_back(mk_rsp(1'b1, mem_word(32'h300), 1'b0));
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (d_ready) seen = 1'b1;
    end
    d_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (!seen || last_acc_len != 6) begin
      $display("FAIL wait_length: got seen=%0b access_cycles=%0d, required 1 6", seen, last_acc_len);
    end else begin
      n_pass++;
    end
    wait_cycles = 0;
    $display("wait-state access done at cycle %0d", cyc);
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit seen = 1'b0;
    last_acc_len = 0;
    never_ready = 1'b1;
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h48;
    acc_q.push_back(mk_acc(32'h48, 1'b0, 4'b1111, 32'h0, 1'b0));
    rsp_q.push_back(mk_rsp(1'b0, 32'hDEAD_BEEF, 1'b1));
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (i_ready) seen = 1'b1;
    end
    i_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (!seen || last_acc_len != TIMEOUT_CYCLES) begin
      $display("FAIL timeout_length: got seen=%0b access_cycles=%0d, required 1 %0d",
               seen, last_acc_len, TIMEOUT_CYCLES);
    end else begin
      n_pass++;
    end
    never_ready = 1'b0;
    // mem_ready on the last permitted cycle completes normally
    seen = 1'b0;
    last_acc_len = 0;
    wait_cycles = TIMEOUT_CYCLES - 1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h50; d_wdata = 32'h1234_5678; d_be = 4'b1100;
    acc_q.push_back(mk_acc(32'h50, 1'b1, 4'b1100, 32'h1234_5678, 1'b1));
    rsp_q.push_back(mk_rsp(1'b1, 32'h0, 1'b0));
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (d_ready) seen = 1'b1;
    end
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    n_checks++;
    if (!seen || last_acc_len != TIMEOUT_CYCLES) begin
      $display("FAIL timeout_race: got seen=%0b access_cycles=%0d, required 1 %0d",
               seen, last_acc_len, TIMEOUT_CYCLES);
    end else begin
      n_pass++;
    end
    wait_cycles = 0;
    $display("timeout accesses done at cycle %0d", cyc);
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid_access();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_wait_states();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    repeat (3) @(negedge clk);
    n_checks++;
    if (acc_q.size() != 0 || rsp_q.size() != 0) begin
      $display("FAIL queues_drained: got accesses=%0d responses=%0d left, required 0 0",
               acc_q.size(), rsp_q.size());
    end else begin
      n_pass++;
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
